// File: rtl/capture_frame_packer_pkg.sv
// Shared types and constants for the PDH capture path.
// Used by the frame packer, its bus interface and its lane slices.
package pdh_capture_pkg;

  localparam int LANE_W       = 16;
  localparam int NUM_LANES    = 4;
  localparam int AVG_LOG2_MAX = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_TRIG,
    ST_RUN
  } capture_state_t;

  typedef enum logic [1:0] {
    TRIG_IMMEDIATE = 2'd0,
    TRIG_RISE      = 2'd1,
    TRIG_FALL      = 2'd2,
    TRIG_RESERVED  = 2'd3
  } trig_mode_t;

endpackage

// File: rtl/capture_frame_packer_if.sv
// Sample-in / packed-word-out bus of the capture frame packer.
// The master side is the upstream PDH datapath feeding samples and
// collecting packed words; the slave side is the packer itself.
interface capture_frame_packer_if;
  import pdh_capture_pkg::*;

  logic                          sample_valid_i;
  logic [LANE_W-1:0]             lane0_i;
  logic [LANE_W-1:0]             lane1_i;
  logic [LANE_W-1:0]             lane2_i;
  logic [LANE_W-1:0]             lane3_i;
  logic [NUM_LANES*LANE_W-1:0]   word_o;
  logic                          word_valid_o;

  modport master (
    output sample_valid_i, lane0_i, lane1_i, lane2_i, lane3_i,
    input  word_o, word_valid_o
  );

  modport slave (
    input  sample_valid_i, lane0_i, lane1_i, lane2_i, lane3_i,
    output word_o, word_valid_o
  );

endinterface

// File: rtl/capture_frame_packer_lane_accumulator.sv
// One lane of the boxcar averager: sign-extends each signed sample,
// accumulates it, and on frame completion registers the arithmetic-
// shifted sum (including the final sample) while restarting at zero.
module lane_accumulator #(
  parameter int LANE_W = 16,
  parameter int ACC_W  = 26
) (
  input  logic              pdh_clk,
  input  logic              rst_i,
  input  logic              clr,
  input  logic              add_en,
  input  logic              load,
  input  logic [3:0]        shift_n,
  input  logic [LANE_W-1:0] sample,
  output logic [LANE_W-1:0] avg
);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] ext;
  logic signed [ACC_W-1:0] sum;

  // Running sum including the sample presented this cycle.
  always_comb begin
    ext = {{(ACC_W-LANE_W){sample[LANE_W-1]}}, sample};
    sum = acc + ext;
  end

  // Clear wins over frame completion, which wins over plain accumulation;
  // completion reloads zero so the next frame starts without a gap.
  always_ff @(posedge pdh_clk or posedge rst_i) begin
    if (rst_i) begin
      acc <= '0;
      avg <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (load) begin
      avg <= LANE_W'(sum >>> shift_n);
      acc <= '0;
    end else if (add_en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/posedge_detector.sv
// Registered rising-edge detector: pulse is high for one cycle,
// one cycle after the level input goes from 0 to 1.
module posedge_detector (
  input  logic pdh_clk,
  input  logic rst_i,
  input  logic level,
  output logic pulse
);

  logic level_q;

  // Keep one cycle of history and flag a 0->1 transition.
  always_ff @(posedge pdh_clk or posedge rst_i) begin
    if (rst_i) begin
      level_q <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      level_q <= level;
      pulse   <= level & ~level_q;
    end
  end

endmodule

// File: rtl/capture_frame_packer.sv
// Capture frame packer: arm/trigger gated boxcar averager that packs
// four averaged PDH lanes into one 64-bit word with a one-cycle strobe.
// Optional build macro CAPTURE_FRAME_TAG_EN replaces lane 3 with a
// 16-bit frame counter that restarts at 0 on every arm edge.
module capture_frame_packer #(
  parameter int AVG_LOG2_MAX = pdh_capture_pkg::AVG_LOG2_MAX,
  parameter int LANE_W       = pdh_capture_pkg::LANE_W
) (
  input  logic                   pdh_clk,
  input  logic                   rst_i,
  capture_frame_packer_if.slave  bus,
  input  logic [3:0]             avg_log2_i,
  input  logic [1:0]             trig_mode_i,
  input  logic                   arm_i,
  input  logic                   trig_i,
  output logic                   armed_o,
  output logic                   running_o
);
  import pdh_capture_pkg::*;

  localparam int CNT_W = AVG_LOG2_MAX;
  localparam int ACC_W = LANE_W + AVG_LOG2_MAX;

  capture_state_t    state;
  trig_mode_t        mode_q;
  logic [3:0]        n_q;
  logic [3:0]        n_clamped;
  logic [CNT_W-1:0]  count;
  logic              trig_q;
  logic              trig_fire;
  logic              arm_rise;
  logic              accept;
  logic              frame_end;
  logic              frame_done;
  logic              word_valid;
  logic [LANE_W-1:0] lane0_avg;
  logic [LANE_W-1:0] lane1_avg;
  logic [LANE_W-1:0] lane2_avg;
  logic [LANE_W-1:0] lane3_word;

  posedge_detector u_arm_edge (
    .pdh_clk (pdh_clk),
    .rst_i   (rst_i),
    .level   (arm_i),
    .pulse   (arm_rise)
  );

  // Trigger qualification, sample acceptance and frame-boundary detection.
  // A sample is taken only in RUN while still armed and not re-arming.
  always_comb begin
    n_clamped = (avg_log2_i > 4'(AVG_LOG2_MAX)) ? 4'(AVG_LOG2_MAX) : avg_log2_i;
    case (mode_q)
      TRIG_RISE: trig_fire = trig_i & ~trig_q;
      TRIG_FALL: trig_fire = ~trig_i & trig_q;
      default:   trig_fire = 1'b1;
    endcase
    accept     = (state == ST_RUN) && arm_i && !arm_rise && bus.sample_valid_i;
    frame_end  = (({1'b0, count} + (CNT_W+1)'(1)) == ((CNT_W+1)'(1) << n_q));
    frame_done = accept && frame_end;
  end

  // Capture control FSM: disarm beats re-arm, which beats trigger and
  // frame bookkeeping; armed_o/running_o are registered with the state.
  always_ff @(posedge pdh_clk or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      mode_q     <= TRIG_IMMEDIATE;
      n_q        <= '0;
      count      <= '0;
      trig_q     <= 1'b0;
      word_valid <= 1'b0;
      armed_o    <= 1'b0;
      running_o  <= 1'b0;
    end else begin
      trig_q     <= trig_i;
      word_valid <= frame_done;
      if (!arm_i) begin
        state     <= ST_IDLE;
        armed_o   <= 1'b0;
        running_o <= 1'b0;
      end else if (arm_rise) begin
        state     <= ST_WAIT_TRIG;
        armed_o   <= 1'b1;
        running_o <= 1'b0;
        n_q       <= n_clamped;
        mode_q    <= trig_mode_t'(trig_mode_i);
        count     <= '0;
      end else begin
        case (state)
          ST_WAIT_TRIG: begin
            if (trig_fire) begin
              state     <= ST_RUN;
              armed_o   <= 1'b0;
              running_o <= 1'b1;
            end
          end
          ST_RUN: begin
            if (accept) begin
              count <= frame_end ? '0 : count + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  lane_accumulator #(.LANE_W(LANE_W), .ACC_W(ACC_W)) u_lane0 (
    .pdh_clk (pdh_clk), .rst_i (rst_i), .clr (arm_rise), .add_en (accept),
    .load (frame_done), .shift_n (n_q), .sample (bus.lane0_i), .avg (lane0_avg)
  );

  lane_accumulator #(.LANE_W(LANE_W), .ACC_W(ACC_W)) u_lane1 (
    .pdh_clk (pdh_clk), .rst_i (rst_i), .clr (arm_rise), .add_en (accept),
    .load (frame_done), .shift_n (n_q), .sample (bus.lane1_i), .avg (lane1_avg)
  );

  lane_accumulator #(.LANE_W(LANE_W), .ACC_W(ACC_W)) u_lane2 (
    .pdh_clk (pdh_clk), .rst_i (rst_i), .clr (arm_rise), .add_en (accept),
    .load (frame_done), .shift_n (n_q), .sample (bus.lane2_i), .avg (lane2_avg)
  );

`ifdef CAPTURE_FRAME_TAG_EN
  logic [LANE_W-1:0] tag_cnt;

  // Frame tag: emit the pre-increment count with each frame, wrap freely.
  always_ff @(posedge pdh_clk or posedge rst_i) begin
    if (rst_i) begin
      tag_cnt    <= '0;
      lane3_word <= '0;
    end else if (arm_rise) begin
      tag_cnt <= '0;
    end else if (frame_done) begin
      lane3_word <= tag_cnt;
      tag_cnt    <= tag_cnt + LANE_W'(1);
    end
  end
`else
  lane_accumulator #(.LANE_W(LANE_W), .ACC_W(ACC_W)) u_lane3 (
    .pdh_clk (pdh_clk), .rst_i (rst_i), .clr (arm_rise), .add_en (accept),
    .load (frame_done), .shift_n (n_q), .sample (bus.lane3_i), .avg (lane3_word)
  );
`endif

  assign bus.word_o       = {lane3_word, lane2_avg, lane1_avg, lane0_avg};
  assign bus.word_valid_o = word_valid;

endmodule

// File: tb/tb_capture_frame_packer.sv
// Scoreboard bench for capture_frame_packer: stimulus pushes expected
// packed words, a negedge monitor pops and compares on every strobe.
module tb_capture_frame_packer;
  import pdh_capture_pkg::*;

  logic        pdh_clk = 1'b0;
  logic        rst_i;
  logic [3:0]  avg_log2_i;
  logic [1:0]  trig_mode_i;
  logic        arm_i;
  logic        trig_i;
  logic        armed_o;
  logic        running_o;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] expQ[$];
  logic [15:0] tbTag;

  capture_frame_packer_if bus ();

  capture_frame_packer dut (
    .pdh_clk     (pdh_clk),
    .rst_i       (rst_i),
    .bus         (bus.slave),
    .avg_log2_i  (avg_log2_i),
    .trig_mode_i (trig_mode_i),
    .arm_i       (arm_i),
    .trig_i      (trig_i),
    .armed_o     (armed_o),
    .running_o   (running_o)
  );

  always #5 pdh_clk = ~pdh_clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge pdh_clk) begin
    if (rst_i === 1'b0 && bus.word_valid_o === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_strobe", 64'(bus.word_valid_o), 64'd0);
      end else begin
        checkOutput("word", bus.word_o, expQ.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge pdh_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] l0, input logic [15:0] l1,
                               input logic [15:0] l2, input logic [15:0] l3);
    bus.sample_valid_i = v;
    bus.lane0_i = l0;
    bus.lane1_i = l1;
    bus.lane2_i = l2;
    bus.lane3_i = l3;
    step();
  endtask

  task automatic pushExpected(input logic [15:0] l0, input logic [15:0] l1,
                              input logic [15:0] l2, input logic [15:0] l3);
`ifdef CAPTURE_FRAME_TAG_EN
    expQ.push_back({tbTag, l2, l1, l0});
    tbTag = tbTag + 16'd1;
`else
    expQ.push_back({l3, l2, l1, l0});
`endif
  endtask

  // Leaves the DUT in WAIT_TRIG (two edges after arm_i rises).
  task automatic armDut(input logic [3:0] n, input logic [1:0] mode);
    bus.sample_valid_i = 1'b0;
    arm_i = 1'b0;
    step();
    step();
    avg_log2_i  = n;
    trig_mode_i = mode;
    arm_i = 1'b1;
    step();
    step();
    tbTag = 16'd0;
  endtask

  task automatic drainCheck(input string name);
    bus.sample_valid_i = 1'b0;
    repeat (3) step();
    checkOutput(name, 64'(expQ.size()), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic        pat [4];
    logic [15:0] l0, l1, l2, l3;
    longint      s0, s1, s2, s3;

    rst_i = 1'b1;
    avg_log2_i = 4'd0;
    trig_mode_i = 2'd0;
    arm_i = 1'b0;
    trig_i = 1'b0;
    tbTag = 16'd0;
    bus.sample_valid_i = 1'b0;
    bus.lane0_i = '0;
    bus.lane1_i = '0;
    bus.lane2_i = '0;
    bus.lane3_i = '0;
    repeat (3) step();
    checkOutput("reset_word", bus.word_o, 64'd0);
    checkOutput("reset_valid", 64'(bus.word_valid_o), 64'd0);
    checkOutput("reset_armed", 64'(armed_o), 64'd0);
    checkOutput("reset_running", 64'(running_o), 64'd0);
    rst_i = 1'b0;
    step();

    $display("[TB] N=2 immediate frame");
    armDut(4'd2, 2'd0);
    checkOutput("n2_armed", 64'(armed_o), 64'd1);
    step();
    checkOutput("n2_running", 64'(running_o), 64'd1);
    checkOutput("n2_not_armed", 64'(armed_o), 64'd0);
    pushExpected(16'h0005, 16'hFFFD, 16'hFFFD, 16'hFFFD);
    applyStimulus(1'b1, 16'd4,     16'hFFFD, 16'hFFFD, 16'hFFFD);
    applyStimulus(1'b1, 16'd8,     16'hFFFD, 16'hFFFD, 16'hFFFD);
    applyStimulus(1'b1, 16'hFFFC,  16'hFFFD, 16'hFFFD, 16'hFFFD);
    checkOutput("n2_no_early_strobe", 64'(bus.word_valid_o), 64'd0);
    applyStimulus(1'b1, 16'd12,    16'hFFFD, 16'hFFFD, 16'hFFFD);
    checkOutput("n2_latency", 64'(bus.word_valid_o), 64'd1);
    drainCheck("n2_drain");

    $display("[TB] reset during partial frame");
    armDut(4'd2, 2'd0);
    step();
    applyStimulus(1'b1, 16'd100, 16'd100, 16'd100, 16'd100);
    applyStimulus(1'b1, 16'd100, 16'd100, 16'd100, 16'd100);
    rst_i = 1'b1;
    arm_i = 1'b0;
    bus.sample_valid_i = 1'b0;
    #1;
    checkOutput("rst_word", bus.word_o, 64'd0);
    checkOutput("rst_valid", 64'(bus.word_valid_o), 64'd0);
    checkOutput("rst_armed", 64'(armed_o), 64'd0);
    checkOutput("rst_running", 64'(running_o), 64'd0);
    step();
    step();
    rst_i = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 16'd7, 16'd7, 16'd7, 16'd7);
    checkOutput("rst_stays_idle", 64'(running_o), 64'd0);
    drainCheck("rst_drain");

    $display("[TB] N=0 pass-through");
    armDut(4'd0, 2'd0);
    step();
    checkOutput("n0_lead", 64'(bus.word_valid_o), 64'd0);
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      l0 = 16'h0100 + 16'(i);
      l1 = 16'h8000 + 16'(i);
      l2 = 16'h7FFF - 16'(i);
      l3 = 16'hABC0 + 16'(i);
      if (pat[i]) pushExpected(l0, l1, l2, l3);
      applyStimulus(pat[i], l0, l1, l2, l3);
      checkOutput("n0_follow", 64'(bus.word_valid_o), 64'(pat[i]));
    end
    drainCheck("n0_drain");

    $display("[TB] falling-edge trigger");
    trig_i = 1'b1;
    armDut(4'd0, 2'd2);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
      checkOutput("fall_wait_armed", 64'(armed_o), 64'd1);
      checkOutput("fall_wait_idle_run", 64'(running_o), 64'd0);
    end
    trig_i = 1'b0;
    applyStimulus(1'b0, 16'h1111, 16'h1111, 16'h1111, 16'h1111);
    checkOutput("fall_running", 64'(running_o), 64'd1);
    checkOutput("fall_disarmed_flag", 64'(armed_o), 64'd0);
    pushExpected(16'h0042, 16'hFF00, 16'h7000, 16'h0001);
    applyStimulus(1'b1, 16'h0042, 16'hFF00, 16'h7000, 16'h0001);
    checkOutput("fall_first_strobe", 64'(bus.word_valid_o), 64'd1);
    drainCheck("fall_drain");

    $display("[TB] disarm mid-frame then clamped N");
    armDut(4'd3, 2'd0);
    step();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 16'd9, 16'd9, 16'd9, 16'd9);
    arm_i = 1'b0;
    applyStimulus(1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
    checkOutput("disarm_armed", 64'(armed_o), 64'd0);
    checkOutput("disarm_running", 64'(running_o), 64'd0);
    drainCheck("disarm_drain");
    armDut(4'd12, 2'd0);
    step();
    checkOutput("clamp_running", 64'(running_o), 64'd1);
    s0 = 0; s1 = 0; s2 = 0; s3 = 0;
    for (int i = 0; i < 1024; i++) begin
      l0 = 16'(i * 37 - 20000);
      l1 = 16'(-(i * 3));
      l2 = i[0] ? 16'h8000 : 16'h7FFF;
      l3 = 16'(i * 64);
      s0 += longint'($signed(l0));
      s1 += longint'($signed(l1));
      s2 += longint'($signed(l2));
      s3 += longint'($signed(l3));
      if (i == 1023) pushExpected(16'(s0 >>> 10), 16'(s1 >>> 10), 16'(s2 >>> 10), 16'(s3 >>> 10));
      applyStimulus(1'b1, l0, l1, l2, l3);
    end
    checkOutput("clamp_strobe_at_1024", 64'(bus.word_valid_o), 64'd1);
    drainCheck("clamp_drain");

`ifdef CAPTURE_FRAME_TAG_EN
    $display("[TB] frame tag wrap");
    armDut(4'd0, 2'd0);
    step();
    for (int i = 0; i < 65538; i++) begin
      l0 = 16'(i);
      l1 = ~16'(i);
      l2 = 16'(i * 3);
      pushExpected(l0, l1, l2, 16'h0000);
      applyStimulus(1'b1, l0, l1, l2, 16'hFFFF);
    end
    drainCheck("tag_drain");
`endif

    arm_i = 1'b0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
